// File: rtl/ram_fault_responder.sv
// ram_fault_responder: DEPTH x DATA_W RAM with one programmable stuck-at or coupling fault,
// used as the device under test for a march BIST.
module ram_fault_responder #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8,
    localparam int DEPTH = 1 << ADDR_W,
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic [DATA_W-1:0] OUT,
    input  logic              CS,
    input  logic              WE,
    input  logic              OE,
    input  logic              fault_cfg_valid,
    output logic              fault_cfg_ready,
    input  logic [1:0]        fault_cfg_type,
    input  logic [ADDR_W-1:0] fault_cfg_addr,
    input  logic [BIT_W-1:0]  fault_cfg_bit,
    input  logic [ADDR_W-1:0] fault_cfg_aggr,
    output logic              fault_active,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count
);
    typedef enum logic [1:0] {IDLE, APPLY, ARMED} state_t;

    state_t            state_q, state_d;
    logic [1:0]        type_q, type_d, cfg_type_eff;
    logic [ADDR_W-1:0] vic_q, vic_d, aggr_q, aggr_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] out_q, out_d, vmask, wdata, rdata;
    logic [CNT_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic              wr, rd, hit, sa0, sa1, cpl;

    assign wr    = CS & WE;
    assign rd    = CS & OE & ~WE;
    assign hit   = ADDRESS == vic_q;
    assign sa0   = type_q == 2'b01;
    assign sa1   = type_q == 2'b10;
    assign cpl   = type_q == 2'b11;
    assign vmask = DATA_W'(1) << bit_q;
    assign wdata = (sa0 && hit) ? (DATA_IN & ~vmask) : (sa1 && hit) ? (DATA_IN | vmask) : DATA_IN;
    assign rdata = (sa0 && hit) ? (mem_q[ADDRESS] & ~vmask) :
                   (sa1 && hit) ? (mem_q[ADDRESS] | vmask) : mem_q[ADDRESS];
    // A coupling fault whose aggressor is its own victim is meaningless, so it degrades to no fault.
    assign cfg_type_eff = (fault_cfg_type == 2'b11 && fault_cfg_aggr == fault_cfg_addr) ? 2'b00 : fault_cfg_type;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            type_q  <= '0;
            vic_q   <= '0;
            aggr_q  <= '0;
            bit_q   <= '0;
            mem_q   <= '{default: '0};
            out_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            vic_q   <= vic_d;
            aggr_q  <= aggr_d;
            bit_q   <= bit_d;
            mem_q   <= mem_d;
            out_q   <= out_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = (state_q == APPLY) ? ((cfg_type_eff != 2'b00) ? ARMED : IDLE) :
                  fault_cfg_valid ? APPLY : state_q;
    end

    always_comb begin
        fault_cfg_ready = state_q != APPLY;
        fault_active    = state_q == ARMED;
    end

    always_comb begin
        type_d = (state_q == APPLY) ? cfg_type_eff   : type_q;
        vic_d  = (state_q == APPLY) ? fault_cfg_addr : vic_q;
        aggr_d = (state_q == APPLY) ? fault_cfg_aggr : aggr_q;
        bit_d  = (state_q == APPLY) ? fault_cfg_bit  : bit_q;
        out_d  = rd ? rdata : out_q;
        wr_d   = (wr && wr_q != '1) ? wr_q + 1'b1 : wr_q;
        rd_d   = (rd && rd_q != '1) ? rd_q + 1'b1 : rd_q;
        mem_d  = mem_q;
        if (wr) mem_d[ADDRESS] = wdata;
        if (wr && cpl && ADDRESS == aggr_q) mem_d[vic_q] = mem_q[vic_q] ^ vmask;
    end

    assign OUT      = out_q;
    assign wr_count = wr_q;
    assign rd_count = rd_q;
endmodule

// File: tb/tb_ram_fault_responder.sv
// tb_ram_fault_responder: directed vectors with hand-computed expectations for ram_fault_responder.
module tb_ram_fault_responder;
    logic       clk = 0, rst_n = 0;
    logic [1:0] address = 0, cfg_addr = 0, cfg_aggr = 0, cfg_type = 0, cfg_bit = 0;
    logic [2:0] data_in = 0, out;
    logic       cs = 0, we = 0, oe = 0, cfg_valid = 0, cfg_ready, active;
    logic [7:0] wr_count, rd_count;
    int         n_run = 0, n_fail = 0;

    ram_fault_responder dut (
        .clk(clk), .rst_n(rst_n), .ADDRESS(address), .DATA_IN(data_in), .OUT(out),
        .CS(cs), .WE(we), .OE(oe), .fault_cfg_valid(cfg_valid), .fault_cfg_ready(cfg_ready),
        .fault_cfg_type(cfg_type), .fault_cfg_addr(cfg_addr), .fault_cfg_bit(cfg_bit),
        .fault_cfg_aggr(cfg_aggr), .fault_active(active), .wr_count(wr_count), .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic acc(input logic c, input logic w, input logic o, input logic [1:0] a, input logic [2:0] d);
        cs = c; we = w; oe = o; address = a; data_in = d;
        @(posedge clk); #1;
        cs = 0; we = 0; oe = 0;
    endtask

    task automatic cfg(input logic [1:0] t, input logic [1:0] a, input logic [1:0] b, input logic [1:0] g);
        cfg_valid = 1; cfg_type = t; cfg_addr = a; cfg_bit = b; cfg_aggr = g;
        @(posedge clk); #1;
        chk("apply_ready", cfg_ready, 0);
        @(posedge clk); #1;
        cfg_valid = 0;
        @(posedge clk); #1;
        chk("single_accept_ready", cfg_ready, 1);
    endtask

    initial begin
        #12;
        chk("rst_out", out, 0);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_active", active, 0);
        chk("rst_wr", wr_count, 0);
        chk("rst_rd", rd_count, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        acc(1, 1, 0, 2, 3'b101);
        acc(1, 0, 1, 2, 0);
        chk("t1_out", out, 3'b101);
        chk("t1_wr", wr_count, 1);
        chk("t1_rd", rd_count, 1);
        cfg(2'b01, 1, 0, 0);
        chk("t2_active", active, 1);
        acc(1, 1, 0, 1, 3'b111);
        acc(1, 0, 1, 1, 0);
        chk("t2_out_sa0", out, 3'b110);
        cfg(2'b11, 3, 2, 0);
        chk("t3_active", active, 1);
        acc(1, 1, 0, 3, 3'b000);
        acc(1, 1, 0, 0, 3'b111);
        acc(1, 0, 1, 3, 0);
        chk("t3_victim", out, 3'b100);
        acc(1, 0, 1, 0, 0);
        chk("t3_aggr", out, 3'b111);
        chk("t3_wr", wr_count, 4);
        chk("t3_rd", rd_count, 4);
        cfg(2'b11, 2, 1, 2);
        chk("t4_active", active, 0);
        acc(1, 1, 0, 1, 3'b111);
        acc(1, 0, 1, 1, 0);
        chk("t4_no_sa0", out, 3'b111);
        acc(1, 1, 0, 0, 3'b001);
        acc(1, 0, 1, 3, 0);
        chk("t4_no_coupling", out, 3'b100);
        acc(1, 1, 1, 0, 3'b010);
        chk("t5_out_held", out, 3'b100);
        chk("t5_rd", rd_count, 6);
        chk("t5_wr", wr_count, 7);
        acc(1, 0, 1, 0, 0);
        chk("t5_written", out, 3'b010);
        acc(0, 0, 1, 1, 0);
        chk("cs_low_hold", out, 3'b010);
        acc(1, 0, 0, 1, 0);
        chk("no_access_rd", rd_count, 7);
        for (int i = 0; i < 260; i++) acc(1, 1, 0, 3, 0);
        chk("wr_saturate", wr_count, 8'hff);
        acc(1, 1, 0, 1, 3'b011);
        cfg_valid = 1; cfg_type = 2'b10; cfg_addr = 0; cfg_bit = 0;
        @(posedge clk); #1;
        chk("t6_in_apply", cfg_ready, 0);
        #2 rst_n = 0;
        #1;
        cfg_valid = 0;
        chk("t6_out", out, 0);
        chk("t6_wr", wr_count, 0);
        chk("t6_rd", rd_count, 0);
        chk("t6_ready", cfg_ready, 1);
        chk("t6_active", active, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        acc(1, 0, 1, 1, 0);
        chk("t6_mem1", out, 0);
        acc(1, 1, 0, 0, 3'b000);
        acc(1, 0, 1, 0, 0);
        chk("t6_no_sa1", out, 0);
        chk("t6_active_after", active, 0);
        chk("t6_rd_after", rd_count, 2);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
